// File: rtl/hazardgen_pkg.sv
// Shared pipeline constants for the hazard controller and its neighbours.
// Stage indices run from Fetch (0) to Writeback.
package hazardpkg;

  localparam int unsigned STAGE_F = 0;
  localparam int unsigned STAGE_D = 1;
  localparam int unsigned STAGE_E = 2;
  localparam int unsigned STAGE_M = 3;
  localparam int unsigned STAGE_W = 4;

endpackage

// File: rtl/hazardgen_if.sv
// Hazard cause/response bundle between the pipeline (master) and hazardgen (slave).
interface hazardgen_if
  import hazardpkg::*;
#(
  parameter int unsigned NSTAGES = STAGE_W + 1,
  parameter int unsigned COUNTW  = 32
);

  logic [NSTAGES-1:0]             StallCause;
  logic [NSTAGES-1:0]             FlushCause;
  logic                           ClearCounters;
  logic                           WDClear;
  logic [NSTAGES-1:0]             Stall;
  logic [NSTAGES-1:0]             Flush;
  logic [NSTAGES-1:0][COUNTW-1:0] StallCnt;
  logic                           Timeout;
  logic                           TimeoutSticky;

  modport master (
    output StallCause, FlushCause, ClearCounters, WDClear,
    input  Stall, Flush, StallCnt, Timeout, TimeoutSticky
  );

  modport slave (
    input  StallCause, FlushCause, ClearCounters, WDClear,
    output Stall, Flush, StallCnt, Timeout, TimeoutSticky
  );

endinterface

// File: rtl/hazardgen_stallctr.sv
// Saturating per-stage stall-origin counter; clear beats a same-cycle increment.
module stallctr
  import hazardpkg::*;
#(
  parameter int unsigned COUNTW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [COUNTW-1:0] cnt
);

  logic [COUNTW-1:0] cntQ, cntD;

  always_comb begin
    cntD = cntQ;
    if (clr) begin
      cntD = '0;
    end else if (inc && (cntQ != '1)) begin
      cntD = cntQ + COUNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign cnt = cntQ;

endmodule

// File: rtl/hazardgen.sv
// Stall/flush controller for an NSTAGES-deep in-order pipeline, with stall-origin
// counters and a Fetch forward-progress watchdog.
module hazardgen
  import hazardpkg::*;
#(
  parameter int unsigned NSTAGES = STAGE_W + 1,
  parameter int unsigned COUNTW  = 32,
  parameter int unsigned WDLIMIT = 1024
) (
  input logic        clk,
  input logic        reset,
  hazardgen_if.slave bus
);

  localparam int unsigned WdW = (WDLIMIT == 0) ? 1 : $clog2(WDLIMIT + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(WDLIMIT);

  typedef enum logic [1:0] {StRun, StStalled, StExpired} wdState_e;

  logic [NSTAGES-1:0] g, stallV, flushV, origin;

  for (genvar i = 0; i < NSTAGES; i++) begin : gStage
    assign g[i] = bus.StallCause[i] & ~bus.FlushCause[i];

    // A stage stalls if it or anything downstream of it stalls; the OR-reduction
    // avoids a self-referencing vector.
    if (i == NSTAGES - 1) begin : gLast
      assign stallV[i] = g[i];
      assign origin[i] = stallV[i];
    end else begin : gMid
      assign stallV[i] = |g[NSTAGES-1:i];
      assign origin[i] = stallV[i] & ~stallV[i+1];
    end

    if (i == 0) begin : gFirst
      assign flushV[i] = 1'b0;
    end else begin : gRest
      assign flushV[i] = (~stallV[i] & stallV[i-1]) | bus.FlushCause[i];
    end

    stallctr #(
      .COUNTW(COUNTW)
    ) uCtr (
      .clk  (clk),
      .reset(reset),
      .clr  (bus.ClearCounters),
      .inc  (origin[i]),
      .cnt  (bus.StallCnt[i])
    );
  end

  assign bus.Stall = stallV;
  assign bus.Flush = flushV;

  wdState_e       stateQ, stateD;
  logic [WdW-1:0] wdCntQ, wdCntD;
  logic           timeoutQ, timeoutD;
  logic           stickyQ, stickyD;
  logic           fetchHeld;

  // Any real flush means the pipeline is moving, so it restarts the watchdog.
  assign fetchHeld = stallV[STAGE_F] & ~(|bus.FlushCause[NSTAGES-1:1]);

  always_comb begin
    stateD   = stateQ;
    wdCntD   = wdCntQ;
    timeoutD = 1'b0;
    case (stateQ)
      StRun: begin
        if (fetchHeld && (WDLIMIT != 0)) begin
          wdCntD = WdW'(1);
          if (WdLimit == WdW'(1)) begin
            stateD   = StExpired;
            timeoutD = 1'b1;
          end else begin
            stateD = StStalled;
          end
        end
      end
      StStalled: begin
        if (!fetchHeld) begin
          stateD = StRun;
          wdCntD = '0;
        end else if (wdCntQ + WdW'(1) == WdLimit) begin
          // This cycle is the WDLIMIT-th consecutive stalled one.
          stateD   = StExpired;
          wdCntD   = WdLimit;
          timeoutD = 1'b1;
        end else begin
          wdCntD = wdCntQ + WdW'(1);
        end
      end
      StExpired: begin
        if (!fetchHeld) begin
          stateD = StRun;
          wdCntD = '0;
        end
      end
      default: begin
        stateD = StRun;
        wdCntD = '0;
      end
    endcase
    stickyD = timeoutD | (stickyQ & ~bus.WDClear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StRun;
      wdCntQ   <= '0;
      timeoutQ <= 1'b0;
      stickyQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      wdCntQ   <= wdCntD;
      timeoutQ <= timeoutD;
      stickyQ  <= stickyD;
    end
  end

  assign bus.Timeout       = timeoutQ;
  assign bus.TimeoutSticky = stickyQ;

endmodule

// File: doc/hazardgen.md
# hazardgen

Parametrised stall/flush controller for an NSTAGES-deep in-order pipeline. It is the generalised successor of the fixed five-stage hazard unit. Upstream logic reduces its hazard sources to one stall cause and one flush cause per stage. This block applies the stall-propagation and first-unstalled-flush rules to those causes, keeps saturating per-stage stall-origin performance counters, and runs a forward-progress watchdog that reports pipeline hangs to the privileged unit.

## Interface
Parameters:
- NSTAGES, 5: pipeline depth; index 0 = Fetch, NSTAGES-1 = Writeback.
- COUNTW, 32: width of each stall counter.
- WDLIMIT, 1024: consecutive Fetch-stalled cycles before timeout; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- StallCause  in  NSTAGES  per-stage stall request.
- FlushCause  in  NSTAGES  per-stage flush request; bit 0 is ignored.
- ClearCounters  in  1  zero all stall counters.
- WDClear  in  1  clear TimeoutSticky.
- Stall  out  NSTAGES  per-stage stall.
- Flush  out  NSTAGES  per-stage flush; bit 0 is tied to 0.
- StallCnt  out  NSTAGES x COUNTW  packed array of stall-origin counts.
- Timeout  out  1  one-cycle pulse when the watchdog expires.
- TimeoutSticky  out  1  level; set on expiry.

## Operation
Combinational path (no state; independent of reset):
- G[i] = StallCause[i] & ~FlushCause[i]. Flush has priority over stall in the same stage.
- Stall[NSTAGES-1] = G[NSTAGES-1]; Stall[i] = G[i] | Stall[i+1].
- Flush[i] = (~Stall[i] & Stall[i-1]) | FlushCause[i] for i ≥ 1; Flush[0] = 0.
- Origin[i] = Stall[i] & ~Stall[i+1]; Origin[NSTAGES-1] = Stall[NSTAGES-1].

Stall counters:
- On each clock, StallCnt[i] increments when Origin[i] = 1.
- Counters saturate at 2^COUNTW−1.
- ClearCounters wins over a simultaneous increment (result is 0).

Watchdog FSM, states RUN, STALLED, EXPIRED; a counter WdCnt tracks consecutive Fetch-stalled cycles.
- RUN:
  - Stall[0] & ~|FlushCause[NSTAGES-1:1] → STALLED, WdCnt = 1.
  - Otherwise stay in RUN.
- STALLED:
  - ~Stall[0] or any FlushCause → RUN, WdCnt = 0.
  - Else if WdCnt == WDLIMIT → EXPIRED, Timeout = 1 on the next cycle, TimeoutSticky set.
  - Else WdCnt++.
- EXPIRED:
  - Timeout = 0.
  - ~Stall[0] or any FlushCause → RUN.
  - Otherwise hold; no re-fire until the FSM returns to RUN.
- WDLIMIT = 0: the FSM stays in RUN; Timeout and TimeoutSticky stay 0.
- TimeoutSticky is cleared by WDClear. A set event in the same cycle wins over WDClear.

## Timing
- Stall and Flush have zero latency; they are pure functions of the current-cycle inputs.
- StallCnt updates at the posedge following the cycle in which Origin is sampled.
- Timeout is registered. It rises in the cycle after the WDLIMIT-th consecutive stalled cycle and is high for exactly one cycle.
- Reset, including reset in mid-stall or in EXPIRED, takes effect at the next posedge:
  - StallCnt = 0.
  - FSM = RUN, WdCnt = 0.
  - Timeout = 0, TimeoutSticky = 0.
- During reset, Stall and Flush still follow their inputs.
- WdCnt width is $clog2(WDLIMIT+1). It never wraps.

## Structure
- A shared package (hazardpkg) holds the stage index constants STAGE_F = 0, STAGE_D, STAGE_E, STAGE_M, STAGE_W.
- The watchdog state typedef stays local to hazardgen.
- Sub-module stallctr, instantiated NSTAGES times through generate: COUNTW-bit saturating counter with inputs clk, reset, clr and inc.
- The combinational stall/flush chain is built with a generate loop. Index 0 and index NSTAGES-1 are the boundary cases.

## Test plan
NSTAGES=5, COUNTW=4, WDLIMIT=4 unless noted.
- StallCause = 00100 (E) held for 3 cycles:
  - Stall = 00111, Flush = 01000 each cycle.
  - StallCnt[2] = 3; all other counters 0.
- StallCause = 00010 with FlushCause = 00010:
  - Stall = 00000, Flush = 00010, no counter change.
- StallCause = 10000 held for 4 cycles:
  - Timeout pulses once in cycle 5 and TimeoutSticky = 1.
  - Hold 3 more cycles: no second pulse.
  - Release: state returns to RUN.
  - WDClear then clears TimeoutSticky.
- Stall held for 3 cycles, then FlushCause = 01000 pulsed, then stall held for 3 more cycles:
  - No Timeout, because WdCnt restarts after the flush.
- Saturation and clear:
  - StallCause = 00001 for 20 cycles → StallCnt[0] = 15.
  - ClearCounters asserted together with an increment → StallCnt[0] = 0.
- Reset asserted in EXPIRED with StallCnt[4] = 7:
  - Next cycle: all counters 0, Timeout = 0, TimeoutSticky = 0.
  - Stall and Flush still track their inputs during reset.
